// File: rtl/reorder_buffer_if.sv
// Dispatch / completion / retirement / recovery signal bundle of the reorder buffer.
// The master side is the pipeline front end (drives dispatch and completions).
interface reorder_buffer_if;
    logic       dispatch;
    logic       disp_isST;
    logic       disp_RegDest;
    logic [5:0] disp_p_rd;
    logic [5:0] disp_old_p_rd;

    logic       cmplt_valid;
    logic [3:0] cmplt_rob;
    logic       cmplt_mispred;

    logic [3:0] rob_num;
    logic       rob_full;
    logic       rob_empty;

    logic       retire_ST;
    logic [3:0] retire_rob;
    logic       retire_RegDest;
    logic [5:0] retire_old_p_rd;

    logic       recover;
    logic [3:0] rec_rob;
    logic [5:0] rec_p_rd;

    modport master (
        output dispatch, disp_isST, disp_RegDest, disp_p_rd, disp_old_p_rd,
        output cmplt_valid, cmplt_rob, cmplt_mispred,
        input  rob_num, rob_full, rob_empty,
        input  retire_ST, retire_rob, retire_RegDest, retire_old_p_rd,
        input  recover, rec_rob, rec_p_rd
    );

    modport slave (
        input  dispatch, disp_isST, disp_RegDest, disp_p_rd, disp_old_p_rd,
        input  cmplt_valid, cmplt_rob, cmplt_mispred,
        output rob_num, rob_full, rob_empty,
        output retire_ST, retire_rob, retire_RegDest, retire_old_p_rd,
        output recover, rec_rob, rec_p_rd
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: in-order allocate/retire, out-of-order completion,
// and a one-entry-per-cycle tail walk that squashes everything younger than a mispredict.
module reorder_buffer (
    input  logic            clk,
    input  logic            rst,
    reorder_buffer_if.slave rob
);

    typedef enum logic {NORMAL, RECOVER} state_t;

    state_t state_q, state_d;

    logic [15:0] valid_q, done_q, is_st_q, reg_dest_q;
    logic [5:0]  p_rd_q     [16];
    logic [5:0]  old_p_rd_q [16];
    logic [3:0]  head_q, tail_q, target_q;
    logic [4:0]  count_q, count_d;

    logic [3:0]  tail_m1, youngest, age_c, age_t;
    logic        in_recover, disp_acc, retire_en, cmplt_hit, mispred_hit;
    logic        start_recover, replace, walk_last;

    // Control decode
    assign in_recover  = (state_q == RECOVER);
    assign tail_m1     = tail_q - 4'd1;
    assign disp_acc    = rob.dispatch && (count_q != 5'd16) && !in_recover;
    assign retire_en   = !in_recover && valid_q[head_q] && done_q[head_q];
    assign cmplt_hit   = rob.cmplt_valid && valid_q[rob.cmplt_rob];
    assign mispred_hit = cmplt_hit && rob.cmplt_mispred;

    // Youngest entry once this cycle's dispatch (if any) has been allocated.
    assign youngest      = disp_acc ? tail_q : tail_m1;
    assign start_recover = !in_recover && mispred_hit && (rob.cmplt_rob != youngest);

    // Age relative to head decides whether a new mispredict is older than the current target.
    assign age_c     = rob.cmplt_rob - head_q;
    assign age_t     = target_q - head_q;
    assign replace   = in_recover && mispred_hit && (age_c < age_t);
    assign walk_last = in_recover && (tail_m1 == target_q + 4'd1) && !replace;

    // Output decode
    assign rob.rob_num         = tail_q;
    assign rob.rob_full        = (count_q == 5'd16);
    assign rob.rob_empty       = (count_q == 5'd0);
    assign rob.retire_ST       = retire_en && is_st_q[head_q];
    assign rob.retire_RegDest  = retire_en && reg_dest_q[head_q];
    assign rob.retire_rob      = head_q;
    assign rob.retire_old_p_rd = old_p_rd_q[head_q];
    assign rob.recover         = in_recover;
    assign rob.rec_rob         = in_recover ? tail_m1 : 4'd0;
    assign rob.rec_p_rd        = in_recover ? p_rd_q[tail_m1] : 6'd0;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            NORMAL: begin
                if (start_recover)
                    state_d = RECOVER;
                if (disp_acc && !retire_en)
                    count_d = count_q + 5'd1;
                else if (!disp_acc && retire_en)
                    count_d = count_q - 5'd1;
            end
            RECOVER: begin
                if (walk_last)
                    state_d = NORMAL;
                count_d = count_q - 5'd1;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst)
            state_q <= NORMAL;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            is_st_q    <= '0;
            reg_dest_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            target_q   <= '0;
            count_q    <= '0;
            // NOTE: the payload array is small and drives retire_old_p_rd directly,
            // so it is reset too, keeping every output at 0 while reset is held.
            for (int i = 0; i < 16; i++) begin
                p_rd_q[i]     <= '0;
                old_p_rd_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;

            if (cmplt_hit)
                done_q[rob.cmplt_rob] <= 1'b1;

            if (start_recover || replace)
                target_q <= rob.cmplt_rob;

            if (disp_acc) begin
                valid_q[tail_q]    <= 1'b1;
                done_q[tail_q]     <= 1'b0;
                is_st_q[tail_q]    <= rob.disp_isST;
                reg_dest_q[tail_q] <= rob.disp_RegDest;
                p_rd_q[tail_q]     <= rob.disp_p_rd;
                old_p_rd_q[tail_q] <= rob.disp_old_p_rd;
                tail_q             <= tail_q + 4'd1;
            end

            if (retire_en) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 4'd1;
            end

            // Squash walk: one youngest entry per cycle; later writes win over a same-cycle completion.
            if (in_recover) begin
                valid_q[tail_m1] <= 1'b0;
                tail_q           <= tail_m1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a deque scoreboard takes retirements from the
// front and squashes from the back, plus directed flag/index checks per scenario.
module tb_reorder_buffer;

    logic clk;
    logic rst;

    reorder_buffer_if rob_bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .rob (rob_bus.slave)
    );

    typedef struct {
        logic [3:0] rob;
        logic       st;
        logic       rd;
        logic [5:0] p_rd;
        logic [5:0] old;
    } ent_t;

    ent_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   ret_cnt = 0;
    int   rec_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rob_bus.dispatch      = 1'b0;
        rob_bus.cmplt_valid   = 1'b0;
        rob_bus.cmplt_mispred = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_rob_num",    rob_bus.rob_num, 0);
        check("rst_full",       rob_bus.rob_full, 0);
        check("rst_empty",      rob_bus.rob_empty, 1);
        check("rst_retire_ST",  rob_bus.retire_ST, 0);
        check("rst_retire_rd",  rob_bus.retire_RegDest, 0);
        check("rst_retire_rob", rob_bus.retire_rob, 0);
        check("rst_retire_old", rob_bus.retire_old_p_rd, 0);
        check("rst_recover",    rob_bus.recover, 0);
        check("rst_rec_rob",    rob_bus.rec_rob, 0);
        check("rst_rec_p_rd",   rob_bus.rec_p_rd, 0);
    endtask

    // Asserts reset immediately (asynchronously), checks outputs, releases after the next edge.
    task automatic do_reset();
        rst                   = 1'b0;
        rob_bus.dispatch      = 1'b0;
        rob_bus.cmplt_valid   = 1'b0;
        rob_bus.cmplt_mispred = 1'b0;
        #2;
        sb.delete();
        ret_cnt = 0;
        rec_cnt = 0;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic dispatch_one(input logic st, input logic rd, input logic [5:0] p,
                                input logic [5:0] old, input logic [3:0] exp_rob);
        ent_t e;
        check("rob_num_at_dispatch", rob_bus.rob_num, exp_rob);
        rob_bus.dispatch      = 1'b1;
        rob_bus.disp_isST     = st;
        rob_bus.disp_RegDest  = rd;
        rob_bus.disp_p_rd     = p;
        rob_bus.disp_old_p_rd = old;
        e = '{rob: exp_rob, st: st, rd: rd, p_rd: p, old: old};
        sb.push_back(e);
        tick();
    endtask

    task automatic complete(input logic [3:0] idx, input logic mispred);
        rob_bus.cmplt_valid   = 1'b1;
        rob_bus.cmplt_rob     = idx;
        rob_bus.cmplt_mispred = mispred;
    endtask

    // Scoreboard monitor: samples on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            if (rob_bus.retire_ST || rob_bus.retire_RegDest) begin
                ret_cnt++;
                if (sb.size() == 0) begin
                    check("retire_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("retire_rob",      rob_bus.retire_rob, e.rob);
                    check("retire_ST",       rob_bus.retire_ST, e.st);
                    check("retire_RegDest",  rob_bus.retire_RegDest, e.rd);
                    check("retire_old_p_rd", rob_bus.retire_old_p_rd, e.old);
                end
            end
            if (rob_bus.recover) begin
                rec_cnt++;
                if (sb.size() == 0) begin
                    check("recover_unexpected", 1, 0);
                end else begin
                    e = sb.pop_back();
                    check("rec_rob",  rob_bus.rec_rob, e.rob);
                    check("rec_p_rd", rob_bus.rec_p_rd, e.p_rd);
                end
            end
        end
    end

    initial begin
        rst                   = 1'b0;
        rob_bus.dispatch      = 1'b0;
        rob_bus.disp_isST     = 1'b0;
        rob_bus.disp_RegDest  = 1'b0;
        rob_bus.disp_p_rd     = '0;
        rob_bus.disp_old_p_rd = '0;
        rob_bus.cmplt_valid   = 1'b0;
        rob_bus.cmplt_rob     = '0;
        rob_bus.cmplt_mispred = 1'b0;
        #3;
        do_reset();

        // Fill to 16; a 17th dispatch is dropped.
        for (int i = 0; i < 16; i++) dispatch_one(1'b0, 1'b1, 6'(i + 16), 6'(i), 4'(i));
        check("full_after_16",  rob_bus.rob_full, 1);
        check("empty_after_16", rob_bus.rob_empty, 0);
        rob_bus.dispatch = 1'b1;
        tick();
        check("rob_num_after_17th", rob_bus.rob_num, 0);
        check("full_after_17th",    rob_bus.rob_full, 1);
        check("no_retire_full",     ret_cnt, 0);

        // Single store retires the cycle after completion.
        do_reset();
        dispatch_one(1'b1, 1'b0, 6'd5, 6'd9, 4'd0);
        check("not_empty_store", rob_bus.rob_empty, 0);
        complete(4'd0, 1'b0);
        tick();
        check("retire_ST_live", rob_bus.retire_ST, 1);
        tick();
        check("retire_ST_after", rob_bus.retire_ST, 0);
        check("empty_after_st",  rob_bus.rob_empty, 1);
        check("ret_cnt_st",      ret_cnt, 1);

        // Out-of-order completion: retirement waits for the head.
        do_reset();
        for (int i = 0; i < 6; i++) dispatch_one(1'b0, 1'b1, 6'(20 + i), 6'(40 + i), 4'(i));
        complete(4'd5, 1'b0);
        idle(2);
        check("head_waits", ret_cnt, 0);
        complete(4'd0, 1'b0);
        idle(4);
        check("head_stalls_at_1", ret_cnt, 1);
        check("rob_num_6",        rob_bus.rob_num, 6);
        check("not_empty_5",      rob_bus.rob_empty, 0);

        // Mispredict on 2 of 0..5: squash 5,4,3 with dispatch held off.
        do_reset();
        for (int i = 0; i < 6; i++) dispatch_one(1'b0, 1'b1, 6'(30 + i), 6'(50 + i), 4'(i));
        complete(4'd2, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            rob_bus.dispatch = 1'b1;
            tick();
        end
        check("walk_len_3",     rec_cnt, 3);
        check("rob_num_3",      rob_bus.rob_num, 3);
        check("sb_left_3",      sb.size(), 3);
        idle(2);
        check("walk_stopped_3", rec_cnt, 3);
        complete(4'd0, 1'b0);
        tick();
        complete(4'd1, 1'b0);
        idle(4);
        check("branch_retired", ret_cnt, 3);
        check("empty_after_br", rob_bus.rob_empty, 1);

        // Older mispredict arrives mid-walk and extends it.
        do_reset();
        for (int i = 0; i < 8; i++) dispatch_one(1'b0, 1'b1, 6'(i), 6'(8 + i), 4'(i));
        complete(4'd4, 1'b1);
        tick();
        complete(4'd1, 1'b1);
        idle(9);
        check("walk_len_6", rec_cnt, 6);
        check("rob_num_2",  rob_bus.rob_num, 2);
        check("sb_left_2",  sb.size(), 2);

        // Wrap-around walk with head at 14.
        do_reset();
        for (int i = 0; i < 14; i++) dispatch_one(1'b0, 1'b1, 6'(i), 6'(i), 4'(i));
        for (int i = 0; i < 14; i++) begin
            complete(4'(i), 1'b0);
            tick();
        end
        idle(2);
        check("drained_14",   ret_cnt, 14);
        check("empty_at_14",  rob_bus.rob_empty, 1);
        for (int i = 0; i < 4; i++) dispatch_one(1'b0, 1'b1, 6'(60 + i), 6'(i), 4'(14 + i));
        complete(4'd15, 1'b1);
        idle(5);
        check("wrap_walk_len", rec_cnt, 2);
        check("wrap_rob_num",  rob_bus.rob_num, 0);
        check("wrap_sb_left",  sb.size(), 2);

        // Mispredict on the youngest entry: no walk.
        do_reset();
        for (int i = 0; i < 4; i++) dispatch_one(1'b0, 1'b1, 6'(i), 6'(i), 4'(i));
        complete(4'd3, 1'b1);
        idle(3);
        check("youngest_no_walk", rec_cnt, 0);
        dispatch_one(1'b0, 1'b1, 6'd44, 6'd4, 4'd4);

        // Same-cycle dispatch makes the branch non-youngest; new entry is squashed.
        do_reset();
        for (int i = 0; i < 4; i++) dispatch_one(1'b0, 1'b1, 6'(10 + i), 6'(i), 4'(i));
        complete(4'd3, 1'b1);
        dispatch_one(1'b0, 1'b1, 6'd33, 6'd7, 4'd4);
        idle(3);
        check("same_cycle_walk", rec_cnt, 1);
        check("same_cycle_tail", rob_bus.rob_num, 4);

        // Reset in the middle of a walk aborts it.
        do_reset();
        for (int i = 0; i < 6; i++) dispatch_one(1'b0, 1'b1, 6'(i + 1), 6'(i), 4'(i));
        complete(4'd0, 1'b1);
        idle(2);
        check("walk_started", rec_cnt, 1);
        do_reset();
        idle(5);
        check("walk_aborted", rec_cnt, 0);
        check("abort_empty",  rob_bus.rob_empty, 1);
        check("abort_rob_num", rob_bus.rob_num, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
